// File: rtl/uart_tx_fifo_drain_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo_drain_if
// Purpose  : Read-side handshake between the TX buffer FIFO and the UART
//            transmit drain.
// Signals  : fifo_empty   - FIFO empty flag (FIFO -> drain)
//            fifo_rd_data - read data, valid the cycle after a pop
//            fifo_rd_en   - one-cycle pop strobe (drain -> FIFO)
// Modports : master - the drain (issues pops)
//            slave  - the FIFO read port
// Revision : 1.0 - initial release
// ============================================================================
interface uart_tx_fifo_drain_if #(
  parameter int DATA_WIDTH = 8
);

  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_rd_data;
  logic                  fifo_rd_en;

  modport master (
    input  fifo_empty,
    input  fifo_rd_data,
    output fifo_rd_en
  );

  modport slave (
    output fifo_empty,
    output fifo_rd_data,
    input  fifo_rd_en
  );

endinterface
`default_nettype wire

// File: rtl/uart_tx_fifo_drain.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo_drain
// Purpose  : Transmit end of the UART datapath. Pops bytes from the TX FIFO
//            and serialises each one as a UART frame: start bit, DATA_WIDTH
//            data bits LSB-first, optional parity bit, STOP_BITS stop bits.
// Ports    : clk     - system clock, rising edge
//            rst     - asynchronous, active-high reset
//            enable  - 1 = fetching new bytes from the FIFO is allowed
//            fifo    - FIFO read handshake (master modport)
//            tx      - serial line, idles high, registered
//            busy    - high while a frame is being fetched or sent
//            tx_done - one-cycle pulse in the first idle cycle after a frame
// Notes    : CLKS_PER_BIT must be >= 2; STOP_BITS must be 1 or 2.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_fifo_drain #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 868,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  wire                         clk,
  input  wire                         rst,
  input  wire                         enable,
  uart_tx_fifo_drain_if.master        fifo,
  output logic                        tx,
  output logic                        busy,
  output logic                        tx_done
);

  localparam int                 c_cnt_w     = $clog2(CLKS_PER_BIT);
  localparam int                 c_idx_w     = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [c_cnt_w-1:0] c_bit_last  = c_cnt_w'(CLKS_PER_BIT - 1);
  localparam logic [c_idx_w-1:0] c_idx_last  = c_idx_w'(DATA_WIDTH - 1);
  localparam logic               c_stop_last = (STOP_BITS > 1);
  localparam logic               c_par_on    = (PARITY_EN != 0);
  localparam logic               c_par_odd   = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_START  = 3'd2,
    S_DATA   = 3'd3,
    S_PARITY = 3'd4,
    S_STOP   = 3'd5
  } state_t;

  state_t                  r_state;
  logic [DATA_WIDTH-1:0]   r_shift;
  logic                    r_parity;
  logic [c_cnt_w-1:0]      r_baud;
  logic [c_idx_w-1:0]      r_bit_idx;
  logic                    r_stop_idx;

  logic                    w_pop;
  logic                    w_bit_end;
  logic [DATA_WIDTH-1:0]   w_shift_nxt;

  // Pop is combinational so the FIFO sees it in the same IDLE cycle the
  // decision is made; reset gates it so no pop can leak out during rst.
  assign w_pop       = (r_state == S_IDLE) && enable && !fifo.fifo_empty && !rst;
  assign fifo.fifo_rd_en = w_pop;

  assign w_bit_end   = (r_baud == c_bit_last);
  assign w_shift_nxt = r_shift >> 1;
  assign busy        = (r_state != S_IDLE);

  // tx is loaded one cycle ahead of each bit so that the registered line
  // changes exactly on the bit boundary; the baud counter restarts at every
  // boundary, so bit periods never accumulate drift across a frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_shift    <= '0;
      r_parity   <= 1'b0;
      r_baud     <= '0;
      r_bit_idx  <= '0;
      r_stop_idx <= 1'b0;
      tx         <= 1'b1;
      tx_done    <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          tx <= 1'b1;
          if (w_pop) begin
            r_state <= S_FETCH;
          end
        end

        // Read data is valid now, one cycle after the pop strobe.
        S_FETCH: begin
          r_shift    <= fifo.fifo_rd_data;
          r_parity   <= c_par_on ? ((^fifo.fifo_rd_data) ^ c_par_odd) : 1'b0;
          r_baud     <= '0;
          r_bit_idx  <= '0;
          r_stop_idx <= 1'b0;
          tx         <= 1'b0;
          r_state    <= S_START;
        end

        S_START: begin
          if (w_bit_end) begin
            r_baud  <= '0;
            tx      <= r_shift[0];
            r_state <= S_DATA;
          end else begin
            r_baud <= r_baud + c_cnt_w'(1);
          end
        end

        S_DATA: begin
          if (w_bit_end) begin
            r_baud <= '0;
            if (r_bit_idx == c_idx_last) begin
              if (c_par_on) begin
                tx      <= r_parity;
                r_state <= S_PARITY;
              end else begin
                tx      <= 1'b1;
                r_state <= S_STOP;
              end
            end else begin
              r_bit_idx <= r_bit_idx + c_idx_w'(1);
              r_shift   <= w_shift_nxt;
              tx        <= w_shift_nxt[0];
            end
          end else begin
            r_baud <= r_baud + c_cnt_w'(1);
          end
        end

        S_PARITY: begin
          if (w_bit_end) begin
            r_baud  <= '0;
            tx      <= 1'b1;
            r_state <= S_STOP;
          end else begin
            r_baud <= r_baud + c_cnt_w'(1);
          end
        end

        S_STOP: begin
          tx <= 1'b1;
          if (w_bit_end) begin
            r_baud <= '0;
            if (r_stop_idx == c_stop_last) begin
              tx_done <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              r_stop_idx <= 1'b1;
            end
          end else begin
            r_baud <= r_baud + c_cnt_w'(1);
          end
        end

        default: begin
          tx      <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo_drain.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_fifo_drain
// Purpose  : Self-checking bench for uart_tx_fifo_drain. Three DUT copies
//            (no parity / 1 stop, even parity / 2 stop, odd parity / 1 stop)
//            share clock, reset, enable and byte pushes. Each copy has a
//            queue-based FIFO and a reference model that turns every popped
//            byte into the expected per-cycle tx waveform.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo_drain;

  localparam int c_cpb   = 4;
  localparam int c_n_cfg = 3;

  logic clk       = 1'b0;
  logic rst       = 1'b1;
  logic enable    = 1'b0;
  logic push_stb  = 1'b0;
  logic [7:0] push_data = 8'h00;

  logic [c_n_cfg-1:0] tx_w;
  logic [c_n_cfg-1:0] busy_w;

  int n_tests = 0;
  int n_fail  = 0;
  event final_ev;

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  for (genvar g = 0; g < c_n_cfg; g++) begin : g_cfg
    localparam int c_par_en  = (g == 0) ? 0 : 1;
    localparam int c_par_odd = (g == 2) ? 1 : 0;
    localparam int c_stop    = (g == 1) ? 2 : 1;

    uart_tx_fifo_drain_if #(.DATA_WIDTH(8)) fifo_if ();

    logic       tx;
    logic       busy;
    logic       tx_done;
    logic       fe      = 1'b1;
    logic [7:0] rd_data = 8'h00;
    logic [7:0] q[$];
    bit         exp_q[$];
    int         pops      = 0;
    int         dones     = 0;
    int         aborts    = 0;
    bit         done_next = 1'b0;

    assign fifo_if.fifo_empty   = fe;
    assign fifo_if.fifo_rd_data = rd_data;
    assign tx_w[g]   = tx;
    assign busy_w[g] = busy;

    uart_tx_fifo_drain #(
      .DATA_WIDTH  (8),
      .CLKS_PER_BIT(c_cpb),
      .PARITY_EN   (c_par_en),
      .PARITY_ODD  (c_par_odd),
      .STOP_BITS   (c_stop)
    ) dut (
      .clk    (clk),
      .rst    (rst),
      .enable (enable),
      .fifo   (fifo_if.master),
      .tx     (tx),
      .busy   (busy),
      .tx_done(tx_done)
    );

    // FIFO model plus frame builder: a pop schedules one FETCH-cycle high
    // level followed by every frame bit repeated c_cpb times.
    always @(posedge clk) begin
      logic [7:0] b;
      bit fb[$];
      if (push_stb) q.push_back(push_data);
      if (fifo_if.fifo_rd_en === 1'b1) begin
        b = (q.size() != 0) ? q.pop_front() : 8'h00;
        rd_data <= b;
        pops++;
        fb.delete();
        fb.push_back(1'b0);
        for (int i = 0; i < 8; i++) fb.push_back(b[i]);
        if (c_par_en != 0) fb.push_back(bit'(($countones(b) + c_par_odd) % 2));
        for (int s = 0; s < c_stop; s++) fb.push_back(1'b1);
        exp_q.push_back(1'b1);
        foreach (fb[i]) for (int c = 0; c < c_cpb; c++) exp_q.push_back(fb[i]);
      end
      fe <= (q.size() == 0);
    end

    // Per-cycle comparison of {rd_en, tx, busy, tx_done}.
    always @(negedge clk) begin
      logic [3:0] want;
      if (rst) begin
        if (exp_q.size() != 0) aborts++;
        exp_q.delete();
        done_next = 1'b0;
        want = 4'b0100;
      end else if (exp_q.size() != 0) begin
        want = {1'b0, exp_q.pop_front(), 1'b1, 1'b0};
        if (exp_q.size() == 0) done_next = 1'b1;
      end else begin
        want = {enable & ~fe, 1'b1, 1'b0, done_next};
        done_next = 1'b0;
      end
      if (tx_done === 1'b1) dones++;
      check_eq($sformatf("cfg%0d rd_en/tx/busy/done", g),
               {28'd0, fifo_if.fifo_rd_en, tx, busy, tx_done}, {28'd0, want});
    end

    initial begin
      @(final_ev);
      check_eq($sformatf("cfg%0d fifo_drained", g), q.size(), 0);
      check_eq($sformatf("cfg%0d frames_done", g), dones, pops - aborts);
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    push_data = b;
    push_stb  = 1'b1;
    @(posedge clk);
    #1;
    push_stb  = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    check_eq("reset_tx",   tx_w,   3'b111);
    check_eq("reset_busy", busy_w, 3'b000);
    #1 rst = 1'b0;
    enable = 1'b1;

    push(8'hA5);               wait_cycles(80);
    push(8'h00); push(8'hFF);  wait_cycles(150);
    push(8'h07);               wait_cycles(80);
    push(8'h3C);               wait_cycles(80);

    // Asynchronous reset during data bit 3 of 0x5A.
    push(8'h5A);
    wait_cycles(19);
    check_eq("busy_before_rst", busy_w, 3'b111);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check_eq("rst_async_tx",   tx_w,   3'b111);
    check_eq("rst_async_busy", busy_w, 3'b000);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    wait_cycles(20);
    push(8'h81);               wait_cycles(80);

    // Drop enable during data bit 2 with three bytes queued.
    push(8'h11); push(8'h22); push(8'h33);
    wait_cycles(12);
    enable = 1'b0;
    wait_cycles(100);
    enable = 1'b1;
    wait_cycles(300);

    // Randomised traffic with random enable toggling.
    repeat (60) begin
      if ($urandom_range(0, 2) != 0) push(8'($urandom));
      if ($urandom_range(0, 7) == 0) enable = ~enable;
      wait_cycles($urandom_range(0, 40));
    end
    enable = 1'b1;
    wait_cycles(3500);

    -> final_ev;
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
